// File: rtl/playfield_mem.sv
// playfield_mem: tetris board store with two combinational read ports, single-cell
// writes and a row-at-a-time line-clear engine that collapses full rows downward.
module playfield_mem #(
   parameter int ROWS   = 12,
   parameter int COLS   = 21,
   parameter int TYPE_W = 3
) (
   input  logic              clk_25_175,
   input  logic              reset,
   input  logic [4:0]        memselector_v,
   input  logic [4:0]        memselector_h,
   output logic [TYPE_W-1:0] blocktype_mem,
   input  logic [4:0]        probe_row,
   input  logic [4:0]        probe_col,
   output logic [TYPE_W-1:0] probe_type,
   input  logic              wr_en,
   input  logic [4:0]        wr_row,
   input  logic [4:0]        wr_col,
   input  logic [TYPE_W-1:0] wr_type,
   input  logic              clear_start,
   output logic              busy,
   output logic              clear_done,
   output logic [3:0]        lines_cleared,
   output logic [15:0]       lines_total
);
   localparam int R_W = $clog2(ROWS);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                          state, state_nx;
   logic [R_W-1:0]                  r;
   logic [COLS-1:0][TYPE_W-1:0]     grid [ROWS];
   logic [ROWS-1:0]                 full;
   logic                            row_full;

   // Index matching against every cell makes out-of-range selects fall through to 0
   always_comb begin
      blocktype_mem = '0;
      probe_type = '0;
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++) begin
            if (memselector_v == 5'(i) && memselector_h == 5'(j)) blocktype_mem = grid[i][j];
            if (probe_row == 5'(i) && probe_col == 5'(j)) probe_type = grid[i][j];
         end
   end

   always_comb begin
      full = '1;
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++)
            if (grid[i][j] == '0) full[i] = 1'b0;
   end

   always_comb begin
      row_full = 1'b0;
      for (int i = 0; i < ROWS; i++)
         if (r == R_W'(i)) row_full = full[i];
   end

   assign busy       = state != IDLE;
   assign clear_done = state == DONE;

   always_comb begin
      state_nx = state == IDLE ? (clear_start ? SCAN : IDLE) :
                 state == SCAN ? ((!row_full && r == '0) ? DONE : SCAN) : IDLE;
   end

   always_ff @(posedge clk_25_175 or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk_25_175 or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ROWS; i++) grid[i] <= '0;
         r             <= '0;
         lines_cleared <= '0;
         lines_total   <= '0;
      end else begin
         if (state == IDLE && wr_en)
            for (int i = 0; i < ROWS; i++)
               for (int j = 0; j < COLS; j++)
                  if (wr_row == 5'(i) && wr_col == 5'(j)) grid[i][j] <= wr_type;
         if (state == IDLE && clear_start) begin
            r             <= R_W'(ROWS - 1);
            lines_cleared <= '0;
         end
         // A full row r is removed by pulling every row above it down one; r stays put for a recheck
         if (state == SCAN) begin
            if (row_full) begin
               for (int k = 1; k < ROWS; k++)
                  if (R_W'(k) <= r) grid[k] <= grid[k-1];
               grid[0]       <= '0;
               lines_cleared <= lines_cleared + 4'd1;
            end else if (r != '0) begin
               r <= r - R_W'(1);
            end
         end
         if (state == DONE) lines_total <= lines_total + 16'(lines_cleared);
      end
   end
endmodule

// File: tb/tb_playfield_mem.sv
// tb_playfield_mem: scenario tasks against a board model; line-clear results go through a scoreboard queue.
module tb_playfield_mem;
   localparam int ROWS = 12;
   localparam int COLS = 21;

   logic        clk_25_175 = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  memselector_v = '0, memselector_h = '0;
   logic [2:0]  blocktype_mem;
   logic [4:0]  probe_row = '0, probe_col = '0;
   logic [2:0]  probe_type;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_row = '0, wr_col = '0;
   logic [2:0]  wr_type = '0;
   logic        clear_start = 1'b0;
   logic        busy, clear_done;
   logic [3:0]  lines_cleared;
   logic [15:0] lines_total;

   playfield_mem dut (
      .clk_25_175(clk_25_175), .reset(reset),
      .memselector_v(memselector_v), .memselector_h(memselector_h), .blocktype_mem(blocktype_mem),
      .probe_row(probe_row), .probe_col(probe_col), .probe_type(probe_type),
      .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_type(wr_type),
      .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
      .lines_cleared(lines_cleared), .lines_total(lines_total)
   );

   always #5 clk_25_175 = ~clk_25_175;

   typedef struct {int lines; int total; int cycles;} exp_t;
   exp_t sb[$];
   exp_t e;

   int n_checks = 0;
   int n_fail = 0;
   int model [ROWS][COLS];
   int dut_board [ROWS][COLS];
   int dut_probe [ROWS][COLS];
   int model_total = 0;

   task automatic idle_inputs();
      wr_en = 1'b0; clear_start = 1'b0; wr_row = '0; wr_col = '0; wr_type = '0;
      memselector_v = '0; memselector_h = '0; probe_row = '0; probe_col = '0;
   endtask

   task automatic snapshot();
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++) begin
            memselector_v = 5'(i); memselector_h = 5'(j);
            probe_row = 5'(i); probe_col = 5'(j);
            #1;
            dut_board[i][j] = int'(blocktype_mem);
            dut_probe[i][j] = int'(probe_type);
         end
   endtask

   task automatic do_write(input int row, input int col, input int typ);
      wr_row = 5'(row); wr_col = 5'(col); wr_type = 3'(typ); wr_en = 1'b1;
      @(posedge clk_25_175); #1;
      wr_en = 1'b0;
      if (row < ROWS && col < COLS) model[row][col] = typ;
   endtask

   // Reference clear: drop every full row and compact the rest toward the bottom
   function automatic int model_clear();
      int f, dst;
      bit is_full;
      int nb [ROWS][COLS];
      f = 0; dst = ROWS - 1;
      for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) nb[i][j] = 0;
      for (int src = ROWS - 1; src >= 0; src--) begin
         is_full = 1'b1;
         for (int j = 0; j < COLS; j++) if (model[src][j] == 0) is_full = 1'b0;
         if (is_full) f++;
         else begin
            for (int j = 0; j < COLS; j++) nb[dst][j] = model[src][j];
            dst--;
         end
      end
      model = nb;
      return f;
   endfunction

   task automatic run_clear(input bit inj, input bit with_wr, input int wr_r, input int wr_c, input int wr_t, input string tag);
      int f, cnt, dones, done_at;
      if (with_wr) begin
         wr_row = 5'(wr_r); wr_col = 5'(wr_c); wr_type = 3'(wr_t); wr_en = 1'b1;
         if (wr_r < ROWS && wr_c < COLS) model[wr_r][wr_c] = wr_t;
      end
      f = model_clear();
      model_total = (model_total + f) % 65536;
      e.lines = f; e.total = model_total; e.cycles = ROWS + f + 1;
      sb.push_back(e);
      clear_start = 1'b1;
      @(posedge clk_25_175); #1;
      clear_start = 1'b0; wr_en = 1'b0;
      cnt = 0; dones = 0; done_at = 0;
      while (busy && cnt < 200) begin
         cnt++;
         if (clear_done) begin dones++; done_at = cnt; end
         if (inj && cnt == 3) begin
            wr_row = 5'd0; wr_col = 5'd0; wr_type = 3'd7; wr_en = 1'b1; clear_start = 1'b1;
         end
         @(posedge clk_25_175); #1;
         wr_en = 1'b0; clear_start = 1'b0;
      end
      e = sb.pop_front();
      n_checks++;
      if (cnt >= 200) begin n_fail++; $display("FAIL %s timeout: busy still high after %0d cycles", tag, cnt); end
      n_checks++;
      if (cnt !== e.cycles) begin n_fail++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, cnt, e.cycles); end
      n_checks++;
      if (dones !== 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d expected 1", tag, dones); end
      n_checks++;
      if (done_at !== e.cycles) begin n_fail++; $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_at, e.cycles); end
      n_checks++;
      if (int'(lines_cleared) !== e.lines) begin n_fail++; $display("FAIL %s lines_cleared: got %0d expected %0d", tag, lines_cleared, e.lines); end
      n_checks++;
      if (int'(lines_total) !== e.total) begin n_fail++; $display("FAIL %s lines_total: got %0d expected %0d", tag, lines_total, e.total); end
   endtask

   task automatic test_reset();
      int bad;
      #2 reset = 1'b0;
      memselector_v = 5'd3; memselector_h = 5'd5; probe_row = 5'd11; probe_col = 5'd20;
      wr_en = 1'b1; wr_row = 5'd3; wr_col = 5'd5; wr_type = 3'd6; clear_start = 1'b1;
      repeat (3) @(posedge clk_25_175);
      #1;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
      n_checks++;
      if (clear_done !== 1'b0) begin n_fail++; $display("FAIL reset clear_done: got %b expected 0", clear_done); end
      n_checks++;
      if (lines_cleared !== 4'd0) begin n_fail++; $display("FAIL reset lines_cleared: got %0d expected 0", lines_cleared); end
      n_checks++;
      if (lines_total !== 16'd0) begin n_fail++; $display("FAIL reset lines_total: got %0d expected 0", lines_total); end
      n_checks++;
      if (blocktype_mem !== 3'd0 || probe_type !== 3'd0) begin
         n_fail++; $display("FAIL reset reads: got %0d/%0d expected 0/0", blocktype_mem, probe_type);
      end
      idle_inputs();
      snapshot();
      bad = 0;
      for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++)
         if (dut_board[i][j] !== 0 || dut_probe[i][j] !== 0) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL reset board: %0d nonzero cells, expected 0", bad); end
      @(negedge clk_25_175);
      reset = 1'b1;
      @(posedge clk_25_175); #1;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset release busy: got %b expected 0", busy); end
   endtask

   task automatic test_write();
      int bad;
      memselector_v = 5'd3; memselector_h = 5'd5; probe_row = 5'd3; probe_col = 5'd5;
      wr_row = 5'd3; wr_col = 5'd5; wr_type = 3'd4; wr_en = 1'b1;
      #1;
      n_checks++;
      if (blocktype_mem !== 3'd0) begin n_fail++; $display("FAIL write pre_edge: got %0d expected 0", blocktype_mem); end
      @(posedge clk_25_175); #1;
      wr_en = 1'b0;
      model[3][5] = 4;
      n_checks++;
      if (blocktype_mem !== 3'd4) begin n_fail++; $display("FAIL write render_read: got %0d expected 4", blocktype_mem); end
      n_checks++;
      if (probe_type !== 3'd4) begin n_fail++; $display("FAIL write probe_read: got %0d expected 4", probe_type); end
      do_write(12, 0, 7);
      do_write(0, 21, 7);
      memselector_v = 5'd12; memselector_h = 5'd0; probe_row = 5'd0; probe_col = 5'd21;
      #1;
      n_checks++;
      if (blocktype_mem !== 3'd0 || probe_type !== 3'd0) begin
         n_fail++; $display("FAIL write out_of_range_read: got %0d/%0d expected 0/0", blocktype_mem, probe_type);
      end
      snapshot();
      bad = 0;
      for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++)
         if (dut_board[i][j] !== model[i][j] || dut_probe[i][j] !== model[i][j]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL write board: %0d cells differ, expected 0", bad); end
      do_write(3, 5, 0);
   endtask

   task automatic test_single_line();
      int bad;
      for (int j = 0; j < COLS; j++) do_write(11, j, 1);
      do_write(10, 0, 2);
      run_clear(1'b0, 1'b0, 0, 0, 0, "single_line");
      snapshot();
      n_checks++;
      if (dut_board[11][0] !== 2 || dut_board[11][1] !== 0) begin
         n_fail++; $display("FAIL single_line cells: (11,0)=%0d (11,1)=%0d expected 2 0", dut_board[11][0], dut_board[11][1]);
      end
      bad = 0;
      for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++)
         if (dut_board[i][j] !== model[i][j] || dut_probe[i][j] !== model[i][j]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL single_line board: %0d cells differ, expected 0", bad); end
   endtask

   task automatic test_two_lines();
      int bad;
      for (int j = 0; j < COLS; j++) begin do_write(11, j, 1); do_write(9, j, 3); end
      do_write(10, 3, 5);
      run_clear(1'b0, 1'b0, 0, 0, 0, "two_lines");
      snapshot();
      n_checks++;
      if (dut_board[11][3] !== 5) begin n_fail++; $display("FAIL two_lines cell: (11,3)=%0d expected 5", dut_board[11][3]); end
      bad = 0;
      for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++)
         if (dut_board[i][j] !== model[i][j] || dut_probe[i][j] !== model[i][j]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL two_lines board: %0d cells differ, expected 0", bad); end
   endtask

   task automatic test_busy_drop();
      int bad;
      run_clear(1'b1, 1'b0, 0, 0, 0, "busy_drop");
      snapshot();
      n_checks++;
      if (dut_board[0][0] !== 0) begin n_fail++; $display("FAIL busy_drop cell: (0,0)=%0d expected 0", dut_board[0][0]); end
      bad = 0;
      for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++)
         if (dut_board[i][j] !== model[i][j]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL busy_drop board: %0d cells differ, expected 0", bad); end
   endtask

   task automatic test_write_with_clear();
      int bad;
      for (int j = 0; j < COLS - 1; j++) do_write(11, j, 2);
      run_clear(1'b0, 1'b1, 11, COLS - 1, 3, "write_with_clear");
      snapshot();
      bad = 0;
      for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++)
         if (dut_board[i][j] !== model[i][j] || dut_probe[i][j] !== model[i][j]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL write_with_clear board: %0d cells differ, expected 0", bad); end
   endtask

   task automatic test_reset_mid_pass();
      int bad;
      for (int j = 0; j < COLS; j++) do_write(11, j, 4);
      do_write(5, 5, 6);
      clear_start = 1'b1;
      @(posedge clk_25_175); #1;
      clear_start = 1'b0;
      repeat (3) @(posedge clk_25_175);
      #3;
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_pass busy_before: got %b expected 1", busy); end
      reset = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || clear_done !== 1'b0) begin
         n_fail++; $display("FAIL mid_pass abort: busy=%b clear_done=%b expected 0 0", busy, clear_done);
      end
      n_checks++;
      if (lines_total !== 16'd0 || lines_cleared !== 4'd0) begin
         n_fail++; $display("FAIL mid_pass counters: total=%0d cleared=%0d expected 0 0", lines_total, lines_cleared);
      end
      snapshot();
      bad = 0;
      for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++)
         if (dut_board[i][j] !== 0 || dut_probe[i][j] !== 0) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL mid_pass board: %0d nonzero cells, expected 0", bad); end
      @(negedge clk_25_175);
      reset = 1'b1;
      repeat (3) @(posedge clk_25_175);
      #1;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_pass after_release busy: got %b expected 0", busy); end
      for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) model[i][j] = 0;
      model_total = 0;
   endtask

   initial begin
      for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) model[i][j] = 0;
      test_reset();
      test_write();
      test_single_line();
      test_two_lines();
      test_busy_drop();
      test_write_with_clear();
      test_reset_mid_pass();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/playfield_mem.md
# playfield_mem

Board-state store for the tetris playfield, sitting directly upstream of the renderer. It answers the renderer's per-pixel cell lookup (row/column select in, block type out) combinationally. It accepts single-cell writes from game logic and provides a second read port for collision probes. It also runs a sequential line-clear engine that removes full rows, shifts the rows above them down, and reports how many lines were cleared.

## Interface
- ROWS, 12, playfield rows; row 0 is the top, max 15
- COLS, 21, playfield columns; column 0 is the left, max 31
- TYPE_W, 3, block-type width; type 0 means empty

Ports:
- clk_25_175  in  1  pixel clock; the only clock
- reset  in  1  asynchronous, active-low; clears everything
- memselector_v  in  5  renderer row select
- memselector_h  in  5  renderer column select
- blocktype_mem  out  TYPE_W  type stored at (memselector_v, memselector_h); combinational
- probe_row  in  5  game-logic read row
- probe_col  in  5  game-logic read column
- probe_type  out  TYPE_W  type stored at (probe_row, probe_col); combinational
- wr_en  in  1  write strobe
- wr_row  in  5  write row
- wr_col  in  5  write column
- wr_type  in  TYPE_W  value to write
- clear_start  in  1  request a line-clear pass
- busy  out  1  clear engine active; writes are refused while high
- clear_done  out  1  one-cycle pulse at the end of a pass
- lines_cleared  out  4  full rows removed by the last pass
- lines_total  out  16  running total of cleared lines; wraps modulo 2^16

## Operation
- Storage is a ROWS×COLS×TYPE_W flop array. Reset clears every cell to 0.
- Read ports:
  - Both read ports are purely combinational.
  - An out-of-range index (row ≥ ROWS or col ≥ COLS) returns 0.
  - Reads reflect the array's current contents, including intermediate states during a pass. Game logic issues clear_start during vertical blank.
- Write:
  - On a clock edge with wr_en=1, busy=0 and an in-range index, cell (wr_row, wr_col) takes the value wr_type.
  - An out-of-range write is ignored.
  - A write attempted while busy=1 is dropped; there is no queueing.
- State machine: IDLE, SCAN, DONE.
  - IDLE: clear_start=1 moves to SCAN, sets row pointer r=ROWS-1 and sets lines_cleared=0. A write in the same cycle is also applied, so the scan sees it.
  - SCAN, row r full (every cell nonzero):
    - In one cycle, row k takes the contents of row k-1 for every k=r down to 1, and row 0 becomes all 0.
    - lines_cleared increments and r is unchanged, so the row is rechecked.
  - SCAN, row r not full:
    - If r>0, r decrements.
    - If r=0, the next state is DONE.
  - DONE: lasts one cycle.
    - clear_done=1.
    - lines_total += lines_cleared.
    - Next state is IDLE.
- busy = (state != IDLE).
- clear_start is ignored while busy=1.
- lines_cleared holds its value until the next accepted clear_start.
- r is ceil(log2(ROWS)) bits wide. lines_cleared never exceeds ROWS.

## Timing
- Reset values:
  - every cell 0
  - state IDLE
  - busy 0, clear_done 0
  - lines_cleared 0, lines_total 0
  - blocktype_mem and probe_type therefore read 0
- Reset is asynchronous: asserting it mid-pass aborts the pass immediately, with no clear_done.
- Read latency is 0 cycles. A write at edge N is visible on both read ports right after edge N.
- Pass length with F full rows removed:
  - SCAN lasts ROWS+F cycles, then DONE lasts 1 cycle.
  - busy is high for ROWS+F+1 cycles, starting in the cycle after the edge that accepted clear_start.
  - clear_done is high in the last busy cycle.
  - lines_total updates on the edge that leaves DONE.
- Row 0 full: it is cleared to empty, rechecked, found not full, and the pass finishes.
- Whole board full: F=ROWS, busy lasts 2·ROWS+1 cycles, and lines_cleared=ROWS.
- Empty board: F=0, and busy lasts ROWS+1 cycles.

## Test plan
- Reset with nonzero stimulus on all inputs:
  - All reads return 0; busy=0, lines_cleared=0, lines_total=0.
  - Asserting reset again mid-pass returns busy to 0 in the same cycle and zeroes the array.
- Write (3,5)=4:
  - blocktype_mem at (3,5) reads 4 right after the edge, and probe_type agrees.
  - A write to (12,0) or (0,21) changes nothing, and reading those indices returns 0.
- Fill row 11 with type 1 and set (10,0)=2, then pulse clear_start:
  - busy stays high 14 cycles and clear_done pulses in cycle 14.
  - lines_cleared=1 and lines_total=1.
  - (11,0) reads 2, (11,1) reads 0, row 0 is empty.
- Fill rows 11 and 9 fully; row 10 holds only (10,3)=5:
  - busy lasts 15 cycles and lines_cleared=2.
  - (11,3) reads 5 and rows 0–10 are empty.
  - lines_total accumulates to 3 after the previous test.
- During busy:
  - wr_en to (0,0)=7 is dropped, and (0,0) reads 0 after the pass.
  - A second clear_start is ignored, so exactly one clear_done pulse occurs.
- In IDLE, wr_en filling the last empty cell of row 11 coincides with clear_start:
  - The pass sees the full row and reports lines_cleared=1.
